weight_fetch_ctrl: RTL and testbench

Sequences reads from the 20000x100b weight SRAM (active-low chip select, registered read data one cycle after the address) for one layer-weight segment per command. Streams the 100-bit words (25 x 4-bit weights) to the PE array over a valid/ready interface. A small prefetch FIFO absorbs the SRAM read latency under backpressure. Sits between the top-level layer FSM and the weight SRAM read port; the write port is not touched.

---
 rtl/weight_map_pkg.sv | 51 +++++
 rtl/wfc_fifo.sv | 50 +++++
 rtl/weight_fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_map_pkg.sv
// Shared widths, FSM/segment enums and the layer-weight segment map of the weight SRAM.
package weight_map_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 100;
    localparam int CNT_W  = 15;

    typedef enum logic [2:0] {
        SEG_CONV1_W = 3'd0,
        SEG_CONV1_B = 3'd1,
        SEG_CONV2_W = 3'd2,
        SEG_CONV2_B = 3'd3,
        SEG_FC1_W   = 3'd4,
        SEG_SCORE_W = 3'd5
    } seg_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic seg_legal(input logic [2:0] sel);
        return (sel <= 3'd5);
    endfunction

    function automatic logic [ADDR_W-1:0] seg_base(input logic [2:0] sel);
        case (sel)
            SEG_CONV1_W: seg_base = 17'd0;
            SEG_CONV1_B: seg_base = 17'd20;
            SEG_CONV2_W: seg_base = 17'd21;
            SEG_CONV2_B: seg_base = 17'd1021;
            SEG_FC1_W:   seg_base = 17'd1100;
            SEG_SCORE_W: seg_base = 17'd17100;
            default:     seg_base = 17'd0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] seg_count(input logic [2:0] sel);
        case (sel)
            SEG_CONV1_W: seg_count = 15'd20;
            SEG_CONV1_B: seg_count = 15'd1;
            SEG_CONV2_W: seg_count = 15'd1000;
            SEG_CONV2_B: seg_count = 15'd2;
            SEG_FC1_W:   seg_count = 15'd16000;
            SEG_SCORE_W: seg_count = 15'd200;
            default:     seg_count = 15'd0;
        endcase
    endfunction

endpackage

// File: rtl/wfc_fifo.sv
// Small synchronous prefetch FIFO holding SRAM words until the PE array accepts them.
module wfc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Storage, pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Streams one layer-weight segment per command from the weight SRAM read port to the
// PE array, throttling reads so every in-flight word has a guaranteed FIFO slot.
module weight_fetch_ctrl
    import weight_map_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        seg_sel,
    output logic              sram_csb,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last,
    output logic              busy,
    output logic              done,
    output logic              cmd_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, raddr_q;
    logic [CNT_W-1:0]  issue_left_q, issue_left_d;
    logic [CNT_W-1:0]  deliver_left_q, deliver_left_d;
    logic              inflight_q;
    logic              cmd_err_q, cmd_err_d;
    logic [DATA_W-1:0] head_s;
    logic [CW-1:0]     fifo_count_s;
    logic              fifo_empty_s, accept_s, pop_s, push_s, issue_s;
    logic [OW-1:0]     occ_s, limit_s;

    // Returning SRAM data bypasses an empty FIFO so the first word appears with no extra cycle.
    assign fifo_empty_s = (fifo_count_s == '0);
    assign w_valid      = !fifo_empty_s || inflight_q;
    assign w_data       = fifo_empty_s ? sram_rdata : head_s;
    assign w_last       = w_valid && (deliver_left_q == CNT_W'(1));
    assign accept_s     = w_valid && w_ready;
    assign pop_s        = accept_s && !fifo_empty_s;
    assign push_s       = inflight_q && !(accept_s && fifo_empty_s);
    assign occ_s        = {1'b0, fifo_count_s} + OW'(inflight_q);
    assign limit_s      = OW'(FIFO_DEPTH) + OW'(accept_s);
    assign issue_s      = (state_q == ST_FETCH) && (issue_left_q != '0) && (occ_s < limit_s);

    wfc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (sram_rdata),
        .head_o  (head_s),
        .count_o (fifo_count_s)
    );

    // Command decode, address/issue/deliver counters and state sequencing.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        issue_left_d   = issue_left_q;
        deliver_left_d = deliver_left_q;
        cmd_err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && seg_legal(seg_sel)) begin
                    state_d        = ST_FETCH;
                    addr_d         = seg_base(seg_sel);
                    issue_left_d   = seg_count(seg_sel);
                    deliver_left_d = seg_count(seg_sel);
                end else if (start) begin
                    cmd_err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (issue_s) begin
                    addr_d       = addr_q + ADDR_W'(1);
                    issue_left_d = issue_left_q - CNT_W'(1);
                end else begin
                    addr_d = addr_q;
                end
                if (accept_s) begin
                    deliver_left_d = deliver_left_q - CNT_W'(1);
                    state_d        = (deliver_left_q == CNT_W'(1)) ? ST_DONE : ST_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers; raddr_q keeps the last issued address visible on the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            raddr_q        <= '0;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            inflight_q     <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            issue_left_q   <= issue_left_d;
            deliver_left_q <= deliver_left_d;
            inflight_q     <= issue_s;
            cmd_err_q      <= cmd_err_d;
            if (issue_s) begin
                raddr_q <= addr_q;
            end
        end
    end

    assign sram_csb   = !issue_s;
    assign sram_raddr = issue_s ? addr_q : raddr_q;
    assign busy       = (state_q == ST_FETCH);
    assign done       = (state_q == ST_DONE);
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Table-driven bench for weight_fetch_ctrl: SRAM model, scoreboard of expected words, hand corner sequences.
module tb_weight_fetch_ctrl;

    localparam int M_ALWAYS = 0;
    localparam int M_RANDOM = 1;
    localparam int M_STALL  = 2;

    typedef struct packed {
        logic [99:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [2:0] seg;
        int         mode;
        logic       inj;
        logic [2:0] inj_sel;
        int         exp_lat;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  seg_sel = 3'd0;
    logic        sram_csb;
    logic [16:0] sram_raddr;
    logic [99:0] sram_rdata = '0;
    logic [99:0] w_data;
    logic        w_valid;
    logic        w_ready = 1'b0;
    logic        w_last;
    logic        busy;
    logic        done;
    logic        cmd_err;

    int checks = 0;
    int errors = 0;

    int bases  [6] = '{0, 20, 21, 1021, 1100, 17100};
    int counts [6] = '{20, 1, 1000, 2, 16000, 200};

    exp_t        sb_q[$];
    int          reads, accepts, done_cnt, last_acc_cyc;
    logic        prev_stall;
    logic [99:0] prev_data;
    logic [16:0] exp_addr;
    cmd_t        tbl [8];

    weight_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seg_sel    (seg_sel),
        .sram_csb   (sram_csb),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .w_data     (w_data),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_last     (w_last),
        .busy       (busy),
        .done       (done),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [99:0] mem_word(input logic [16:0] a);
        logic [31:0] h;
        h = {15'd0, a} * 32'h9E3779B1;
        return {h, h ^ 32'hA5A5A5A5, h[18:0], a};
    endfunction

    // Weight SRAM read port: data registered one cycle after chip select low.
    always @(posedge clk) begin
        if (!sram_csb) sram_rdata <= mem_word(sram_raddr);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            M_RANDOM: return 1'($urandom_range(0, 1));
            M_STALL:  return (cyc > 10);
            default:  return 1'b1;
        endcase
    endfunction

    task automatic init_tracking(input int base, input int cnt);
        exp_t e;
        sb_q.delete();
        reads = 0; accepts = 0; done_cnt = 0; last_acc_cyc = -1;
        prev_stall = 1'b0; prev_data = '0;
        exp_addr = 17'(base);
        for (int i = 0; i < cnt; i++) begin
            e.data = mem_word(17'(base + i));
            e.last = (i == cnt - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic sample_cycle(input int cyc);
        exp_t e;
        if (!sram_csb) begin
            reads++;
            chk("raddr", sram_raddr, exp_addr);
            exp_addr++;
        end
        if (prev_stall) begin
            chk("hold_valid", w_valid, 1);
            chk("hold_data", w_data, prev_data);
        end
        if (w_valid && w_ready) begin
            accepts++;
            last_acc_cyc = cyc;
            chk("word_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("w_data", w_data, e.data);
                chk("w_last", w_last, e.last);
            end
        end
        chk("outstanding_le_2", 32'((reads - accepts) <= 2), 1);
        chk("cmd_err_quiet", cmd_err, 0);
        if (done) begin
            done_cnt++;
            chk("done_timing", cyc, last_acc_cyc + 1);
            chk("busy_at_done", busy, 0);
        end else begin
            chk("busy", busy, cyc >= 1);
        end
        prev_stall = w_valid && !w_ready;
        prev_data  = w_data;
    endtask

    task automatic run_cmd(input cmd_t c);
        int   base, cnt, budget;
        logic legal;
        legal = (c.seg <= 3'd5);
        base  = legal ? bases[c.seg] : 0;
        cnt   = legal ? counts[c.seg] : 0;
        init_tracking(base, cnt);
        @(posedge clk); #1;
        start = 1'b1; seg_sel = c.seg; w_ready = ready_for(c.mode, 0); #1;
        if (!legal) begin
            chk("err_c0_csb", sram_csb, 1);
            @(posedge clk); #1; start = 1'b0; #1;
            chk("cmd_err_pulse", cmd_err, 1);
            chk("err_busy", busy, 0);
            chk("err_csb", sram_csb, 1);
            @(posedge clk); #2;
            chk("cmd_err_single", cmd_err, 0);
            chk("err_busy2", busy, 0);
            return;
        end
        sample_cycle(0);
        budget = cnt * 4 + 40;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk); #1;
            start = c.inj && (cyc == 5);
            if (start) seg_sel = c.inj_sel;
            w_ready = ready_for(c.mode, cyc); #1;
            sample_cycle(cyc);
            if (c.mode == M_STALL && cyc == 10) chk("stall_reads", reads, 2);
            if (done) break;
        end
        chk("done_count", done_cnt, 1);
        chk("word_count", accepts, cnt);
        chk("read_count", reads, cnt);
        chk("sb_empty", sb_q.size(), 0);
        if (c.exp_lat > 0) chk("latency", last_acc_cyc + 1, c.exp_lat);
        @(posedge clk); #1; start = 1'b0; w_ready = 1'b0; #1;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_csb", sram_csb, 1);
    endtask

    initial begin
        tbl[0] = '{seg: 3'd1, mode: M_ALWAYS, inj: 1'b0, inj_sel: 3'd0, exp_lat: 3};
        tbl[1] = '{seg: 3'd0, mode: M_ALWAYS, inj: 1'b1, inj_sel: 3'd5, exp_lat: 22};
        tbl[2] = '{seg: 3'd2, mode: M_ALWAYS, inj: 1'b1, inj_sel: 3'd7, exp_lat: 1002};
        tbl[3] = '{seg: 3'd5, mode: M_RANDOM, inj: 1'b1, inj_sel: 3'd2, exp_lat: -1};
        tbl[4] = '{seg: 3'd3, mode: M_STALL,  inj: 1'b0, inj_sel: 3'd0, exp_lat: -1};
        tbl[5] = '{seg: 3'd7, mode: M_ALWAYS, inj: 1'b0, inj_sel: 3'd0, exp_lat: -1};
        tbl[6] = '{seg: 3'd6, mode: M_ALWAYS, inj: 1'b0, inj_sel: 3'd0, exp_lat: -1};
        tbl[7] = '{seg: 3'd4, mode: M_ALWAYS, inj: 1'b0, inj_sel: 3'd0, exp_lat: 16002};

        repeat (3) @(posedge clk);
        #2;
        chk("rst_csb", sram_csb, 1);
        chk("rst_raddr", sram_raddr, 0);
        chk("rst_valid", w_valid, 0);
        chk("rst_last", w_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_err", cmd_err, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // conv1_b single word, then a start landing in the DONE cycle
        @(posedge clk); #1; start = 1'b1; seg_sel = 3'd1; w_ready = 1'b1; #1;
        @(posedge clk); #1; start = 1'b0; #1;
        chk("s1_csb", sram_csb, 0);
        chk("s1_raddr", sram_raddr, 20);
        @(posedge clk); #2;
        chk("s1_valid", w_valid, 1);
        chk("s1_last", w_last, 1);
        chk("s1_data", w_data, mem_word(17'd20));
        @(posedge clk); #1; start = 1'b1; seg_sel = 3'd0; #1;
        chk("s1_done", done, 1);
        @(posedge clk); #1; start = 1'b0; #1;
        chk("s1_ign_busy", busy, 0);
        chk("s1_ign_csb", sram_csb, 1);
        @(posedge clk); #2;
        chk("s1_ign_busy2", busy, 0);
        chk("s1_ign_csb2", sram_csb, 1);

        // fc1_w interrupted by reset after 37 words
        init_tracking(1100, 16000);
        @(posedge clk); #1; start = 1'b1; seg_sel = 3'd4; w_ready = 1'b1; #1;
        sample_cycle(0);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1; start = 1'b0; #1;
            sample_cycle(cyc);
            if (accepts == 37) break;
        end
        chk("pre_reset_words", accepts, 37);
        rst_n = 1'b0; #1;
        chk("mid_rst_csb", sram_csb, 1);
        chk("mid_rst_raddr", sram_raddr, 0);
        chk("mid_rst_valid", w_valid, 0);
        chk("mid_rst_last", w_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        sb_q.delete();
        repeat (2) begin
            @(posedge clk); #2;
            chk("rst_no_done", done, 0);
        end
        @(posedge clk); #1; rst_n = 1'b1; w_ready = 1'b0;
        run_cmd('{seg: 3'd0, mode: M_ALWAYS, inj: 1'b0, inj_sel: 3'd0, exp_lat: 22});

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
